// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit arbiter slice.
package uart_pkg;

  localparam int unsigned STATE_W   = 2;
  localparam int unsigned MAX_REQ   = 8;
  localparam int unsigned MAX_IDX_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE,
    LOAD,
    WAIT_DONE,
    GAP
  } arb_state_t;

  // One-hot pick of the first set bit of valid, scanning ptr, ptr+1, ... mod n.
  function automatic logic [MAX_REQ-1:0] rr_pick(
    input logic [MAX_REQ-1:0]   valid,
    input logic [MAX_IDX_W-1:0] ptr,
    input int unsigned          n
  );
    logic [MAX_REQ-1:0] pick;
    logic               found;
    int unsigned        idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      idx = (32'(ptr) + i) % n;
      if (i < n && !found && valid[idx[MAX_IDX_W-1:0]]) begin
        pick[idx[MAX_IDX_W-1:0]] = 1'b1;
        found                    = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_arbiter_comb.sv
// Combinational round-robin picker: one-hot grant and its index.
module rr_arbiter_comb
  import uart_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index,
  output logic          any
);

  logic [MAX_REQ-1:0]   v_ext;
  logic [MAX_REQ-1:0]   pick;
  logic [MAX_IDX_W-1:0] p_ext;

  always_comb begin
    v_ext          = '0;
    v_ext[N-1:0]   = valid;
    p_ext          = '0;
    p_ext[IW-1:0]  = ptr;
    pick           = rr_pick(v_ext, p_ext, N);
    grant          = pick[N-1:0];
    index          = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (pick[k]) index = IW'(k);
    end
    any = |valid;
  end

endmodule

// File: rtl/uart_tx.sv
// Existing 8N1 serial transmitter (no reset); Done pulses two cycles per byte.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input  logic       i_Clock,
  input  logic       i_Tx_DV,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Active,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Done
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP,
    TX_CLEANUP
  } tx_state_t;

  tx_state_t   state;
  logic [CW-1:0] clk_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  data;

  always_ff @(posedge i_Clock) begin
    case (state)
      TX_IDLE: begin
        o_Tx_Serial <= 1'b1;
        o_Tx_Done   <= 1'b0;
        clk_cnt     <= '0;
        bit_idx     <= '0;
        if (i_Tx_DV) begin
          o_Tx_Active <= 1'b1;
          data        <= i_Tx_Byte;
          state       <= TX_START;
        end else begin
          o_Tx_Active <= 1'b0;
        end
      end
      TX_START: begin
        o_Tx_Serial <= 1'b0;
        if (clk_cnt < CW'(CLKS_PER_BIT - 1)) clk_cnt <= clk_cnt + 1'b1;
        else begin
          clk_cnt <= '0;
          state   <= TX_DATA;
        end
      end
      TX_DATA: begin
        o_Tx_Serial <= data[bit_idx];
        if (clk_cnt < CW'(CLKS_PER_BIT - 1)) clk_cnt <= clk_cnt + 1'b1;
        else begin
          clk_cnt <= '0;
          if (bit_idx < 3'd7) bit_idx <= bit_idx + 1'b1;
          else begin
            bit_idx <= '0;
            state   <= TX_STOP;
          end
        end
      end
      TX_STOP: begin
        o_Tx_Serial <= 1'b1;
        if (clk_cnt < CW'(CLKS_PER_BIT - 1)) clk_cnt <= clk_cnt + 1'b1;
        else begin
          o_Tx_Done <= 1'b1;
          clk_cnt   <= '0;
          state     <= TX_CLEANUP;
        end
      end
      TX_CLEANUP: begin
        o_Tx_Done <= 1'b1;
        state     <= TX_IDLE;
      end
      default: state <= TX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-locked sharing of one uart_tx among N_REQ byte streams.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic               i_Clock,
  input  logic               i_Rst_n,
  input  logic [N_REQ-1:0]   i_Req_Valid,
  input  logic [8*N_REQ-1:0] i_Req_Data,
  input  logic [N_REQ-1:0]   i_Req_Last,
  output logic [N_REQ-1:0]   o_Req_Ready,
  output logic [N_REQ-1:0]   o_Grant,
  output logic               o_Tx_DV,
  output logic [7:0]         o_Tx_Byte,
  input  logic               i_Tx_Active,
  input  logic               i_Tx_Done,
  output logic               o_Busy
);

  localparam int unsigned IW = $clog2(N_REQ);
  localparam int unsigned CW = (MAX_BURST == 0) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BURST_LIM = CW'(MAX_BURST);

  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d, ready_q, ready_d;
  logic [IW-1:0]    gidx_q, gidx_d, rr_q, rr_d, rr_next;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last_q, last_d, prev_done_q, dv_q, dv_d;
  logic [7:0]       byte_q, byte_d, sel_data;
  logic             sel_valid, sel_last, tx_free, done_rise, burst_full;
  logic [N_REQ-1:0] pick_grant;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;

  rr_arbiter_comb #(.N(N_REQ), .IW(IW)) u_rr (
    .valid (i_Req_Valid),
    .ptr   (rr_q),
    .grant (pick_grant),
    .index (pick_idx),
    .any   (pick_any)
  );

  assign tx_free    = ~i_Tx_Active & ~i_Tx_Done;
  assign done_rise  = i_Tx_Done & ~prev_done_q;
  assign burst_full = (MAX_BURST != 0) && (cnt_q == BURST_LIM);
  assign rr_next    = (gidx_q == IW'(N_REQ - 1)) ? '0 : gidx_q + 1'b1;

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (gidx_q == IW'(k)) begin
        sel_valid = i_Req_Valid[k];
        sel_last  = i_Req_Last[k];
        sel_data  = i_Req_Data[8*k +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    ready_d = '0;
    dv_d    = 1'b0;
    byte_d  = byte_q;
    case (state_q)
      IDLE: begin
        if (pick_any && tx_free) begin
          grant_d = pick_grant;
          gidx_d  = pick_idx;
          cnt_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (sel_valid) begin
          ready_d = grant_q;
          dv_d    = 1'b1;
          byte_d  = sel_data;
          last_d  = sel_last;
          // Saturate so unlimited mode keeps the message lock indefinitely.
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          state_d = WAIT_DONE;
        end else if (cnt_q == '0) begin
          grant_d = '0;
          state_d = IDLE;
        end
      end
      WAIT_DONE: begin
        if (done_rise) state_d = GAP;
      end
      GAP: begin
        if (tx_free) begin
          if (last_q || burst_full) begin
            rr_d    = rr_next;
            grant_d = '0;
            state_d = IDLE;
          end else begin
            state_d = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      gidx_q      <= '0;
      rr_q        <= '0;
      cnt_q       <= '0;
      last_q      <= 1'b0;
      prev_done_q <= 1'b0;
      ready_q     <= '0;
      dv_q        <= 1'b0;
      byte_q      <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      gidx_q      <= gidx_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      prev_done_q <= i_Tx_Done;
      ready_q     <= ready_d;
      dv_q        <= dv_d;
      byte_q      <= byte_d;
    end
  end

  assign o_Grant     = grant_q;
  assign o_Req_Ready = ready_q;
  assign o_Tx_DV     = dv_q;
  assign o_Tx_Byte   = byte_q;
  assign o_Busy      = (state_q != IDLE);

endmodule
